// File: rtl/alu_cmd_ctrl.sv
// alu_cmd_ctrl: byte-frame command front-end for the unsigned ALU.
// Parses CC/DD frames from the UART RX parallel interface, loads operands and
// function code, pulses the ALU enable, gates the ALU clock while a result is
// pending, and streams the 16-bit result LSB-first into the TX FIFO.
module alu_cmd_ctrl #(
    parameter int                    DATA_WIDTH    = 8,
    parameter int                    OP_CODE_WIDTH = 4,
    parameter logic [DATA_WIDTH-1:0] CMD_ALU_OP    = 8'hCC,
    parameter logic [DATA_WIDTH-1:0] CMD_ALU_NOP   = 8'hDD,
    parameter int                    WAIT_TIMEOUT  = 4
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [DATA_WIDTH-1:0]      RX_P_DATA,
    input  logic                       RX_D_VLD,
    input  logic [2*DATA_WIDTH-1:0]    ALU_OUT,
    input  logic                       ALU_OUT_VALID,
    input  logic                       FIFO_FULL,
    output logic [DATA_WIDTH-1:0]      ALU_A,
    output logic [DATA_WIDTH-1:0]      ALU_B,
    output logic [OP_CODE_WIDTH-1:0]   ALU_FUN,
    output logic                       ALU_EN,
    output logic                       CLK_GATE_EN,
    output logic [DATA_WIDTH-1:0]      TX_P_DATA,
    output logic                       TX_D_VLD,
    output logic                       BUSY,
    output logic                       CMD_ERR
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] GET_A    = 3'd1;
    localparam logic [2:0] GET_B    = 3'd2;
    localparam logic [2:0] GET_FUN  = 3'd3;
    localparam logic [2:0] RUN      = 3'd4;
    localparam logic [2:0] WAIT_RES = 3'd5;
    localparam logic [2:0] SEND_LO  = 3'd6;
    localparam logic [2:0] SEND_HI  = 3'd7;

    localparam int               CNT_W    = $clog2(WAIT_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_TIMEOUT - 1);

    logic [2:0]              state;
    logic [2:0]              next_state;
    logic                    err_next;
    logic [CNT_W-1:0]        wait_cnt;
    logic [2*DATA_WIDTH-1:0] result;
    logic                    in_send;

    assign in_send  = (state == SEND_LO) || (state == SEND_HI);
    // A byte is written only when the FIFO can take it, so each byte lands exactly once.
    assign TX_D_VLD = in_send && !FIFO_FULL;
    assign BUSY     = (state != IDLE);

    // Present the result byte for the current SEND state; zero elsewhere.
    always_comb begin
        TX_P_DATA = '0;
        if (state == SEND_LO)
            TX_P_DATA = result[DATA_WIDTH-1:0];
        else if (state == SEND_HI)
            TX_P_DATA = result[2*DATA_WIDTH-1:DATA_WIDTH];
    end

    // Frame parser / result handshake next-state logic.
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        next_state = state;
        err_next   = 1'b0;
        case (state)
            IDLE: begin
                if (RX_D_VLD) begin
                    if (RX_P_DATA == CMD_ALU_OP)
                        next_state = GET_A;
                    else if (RX_P_DATA == CMD_ALU_NOP)
                        next_state = GET_FUN;
                    else
                        err_next = 1'b1;
                end
            end
            GET_A:    if (RX_D_VLD) next_state = GET_B;
            GET_B:    if (RX_D_VLD) next_state = GET_FUN;
            GET_FUN:  if (RX_D_VLD) next_state = RUN;
            RUN:      next_state = WAIT_RES;
            WAIT_RES: begin
                if (ALU_OUT_VALID) begin
                    next_state = SEND_LO;
                end else if (wait_cnt == CNT_LAST) begin
                    next_state = IDLE;
                    err_next   = 1'b1;
                end
            end
            SEND_LO:  if (TX_D_VLD) next_state = SEND_HI;
            SEND_HI:  if (TX_D_VLD) next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLK or negedge RST) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!RST)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Operand and function-code registers; they keep their value until reloaded.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ALU_A   <= '0;
            ALU_B   <= '0;
            ALU_FUN <= '0;
        end else if (RX_D_VLD) begin
            case (state)
                GET_A:   ALU_A   <= RX_P_DATA;
                GET_B:   ALU_B   <= RX_P_DATA;
                GET_FUN: ALU_FUN <= RX_P_DATA[OP_CODE_WIDTH-1:0];
                default: ;
            endcase
        end
    end

    // Capture the ALU result when it is flagged valid while waiting.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            result <= '0;
        else if (state == WAIT_RES && ALU_OUT_VALID)
            result <= ALU_OUT;
    end

    // Timeout counter: counts WAIT_RES cycles, clears whenever WAIT_RES is left.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            wait_cnt <= '0;
        else if (state == WAIT_RES && next_state == WAIT_RES)
            wait_cnt <= wait_cnt + 1'b1;
        else
            wait_cnt <= '0;
    end

    // Registered decodes of the next state keep the ALU enable and the clock-gate
    // enable glitch-free; the gate stays open through WAIT_RES so the ALU can drop
    // its valid flag.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ALU_EN      <= 1'b0;
            CLK_GATE_EN <= 1'b0;
            CMD_ERR     <= 1'b0;
        end else begin
            ALU_EN      <= (next_state == RUN);
            CLK_GATE_EN <= (next_state == RUN) || (next_state == WAIT_RES);
            CMD_ERR     <= err_next;
        end
    end

endmodule

// File: doc/alu_cmd_ctrl.md
Name: alu_cmd_ctrl

Overview:
- Command front-end for the unsigned ALU.
- Parses byte frames from the UART RX parallel interface and loads operands and function code.
- Drives a single-cycle ALU enable and gates the ALU clock for low power.
- Captures the 16-bit registered ALU result and writes it LSB-first into the TX FIFO under full-flag back-pressure.

Parameters:
- DATA_WIDTH, 8, byte/operand width.
- OP_CODE_WIDTH, 4, ALU function code width.
- CMD_ALU_OP, 8'hCC, frame: opcode, A, B, FUN.
- CMD_ALU_NOP, 8'hDD, frame: opcode, FUN (reuses stored A/B).
- WAIT_TIMEOUT, 4, max cycles in WAIT_RES before abort.

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous, active-low reset.
- RX_P_DATA  in  8  received byte.
- RX_D_VLD  in  1  single-cycle strobe; RX_P_DATA valid.
- ALU_OUT  in  16  registered ALU result.
- ALU_OUT_VALID  in  1  ALU result valid.
- FIFO_FULL  in  1  TX FIFO full.
- ALU_A  out  8  operand A register.
- ALU_B  out  8  operand B register.
- ALU_FUN  out  4  function code register (RX_P_DATA[3:0]).
- ALU_EN  out  1  ALU enable, one cycle.
- CLK_GATE_EN  out  1  ALU clock-gate enable.
- TX_P_DATA  out  8  byte to FIFO.
- TX_D_VLD  out  1  FIFO write strobe.
- BUSY  out  1  high in every state except IDLE.
- CMD_ERR  out  1  one-cycle error pulse.

Behaviour:
- Reset (async, RST low): state IDLE; ALU_A, ALU_B, ALU_FUN, result register, timeout counter = 0; ALU_EN, CLK_GATE_EN, TX_D_VLD, BUSY, CMD_ERR = 0; TX_P_DATA = 0.
- Reset mid-frame or mid-send aborts the frame; no partial FIFO write after release.
- States: IDLE, GET_A, GET_B, GET_FUN, RUN, WAIT_RES, SEND_LO, SEND_HI.
- IDLE:
  - RX_D_VLD with CMD_ALU_OP -> GET_A.
  - RX_D_VLD with CMD_ALU_NOP -> GET_FUN.
  - Any other byte -> CMD_ERR pulse next cycle; stay in IDLE.
- GET_A: on RX_D_VLD, ALU_A <= byte -> GET_B.
- GET_B: on RX_D_VLD, ALU_B <= byte -> GET_FUN.
- GET_FUN: on RX_D_VLD, ALU_FUN <= byte[3:0] -> RUN. Upper nibble ignored.
- Without RX_D_VLD, every GET state holds indefinitely.
- RX_D_VLD in RUN/WAIT_RES/SEND_*: byte dropped silently; no state effect.
- RUN (one cycle): ALU_EN = 1, CLK_GATE_EN = 1 -> WAIT_RES.
- WAIT_RES:
  - CLK_GATE_EN = 1, ALU_EN = 0; counter increments each cycle.
  - ALU_OUT_VALID = 1 -> capture ALU_OUT into result register -> SEND_LO. Nominal: first WAIT_RES cycle, i.e. result 1 cycle after ALU_EN.
  - Counter reaches WAIT_TIMEOUT without valid -> CMD_ERR pulse -> IDLE; no FIFO write.
  - Counter clears on exit.
- CLK_GATE_EN and ALU_EN are registered state decodes, glitch-free.
- CLK_GATE_EN stays high through WAIT_RES so the ALU clears its valid flag.
- SEND_LO:
  - TX_P_DATA = result[7:0].
  - TX_D_VLD = !FIFO_FULL (combinational).
  - Advances to SEND_HI only on a cycle with TX_D_VLD = 1.
- SEND_HI: same rule with result[15:8] -> IDLE.
- FIFO_FULL held: remain in the SEND state with TX_D_VLD = 0; data held stable. Exactly one write per byte.
- Back-to-back frames: a new opcode is accepted in the first IDLE cycle after SEND_HI completes.
- ALU_A, ALU_B, ALU_FUN hold their values until overwritten. The NOP frame uses the last loaded A/B.

Test Plan:
- Reset: RST low mid-SEND_LO -> all outputs 0, state IDLE. After release, no TX_D_VLD until a new frame.
- Add: CC,05,03,00 with FIFO_FULL = 0 -> ALU_EN one cycle after FUN byte. Writes 08 then 00 on consecutive cycles; BUSY falls after second write.
- Mul via NOP: CC,FF,FF,02 then DD,02 -> both frames write 01 then FE (0xFE01).
- Back-pressure: CC,10,20,00 with FIFO_FULL high 5 cycles at SEND_LO -> TX_D_VLD low 5 cycles, TX_P_DATA = 30 stable. Then 30 and 00 each written exactly once.
- Errors:
  - Byte 0x55 in IDLE -> CMD_ERR single pulse; BUSY stays 0.
  - ALU_OUT_VALID tied 0 -> CMD_ERR after WAIT_TIMEOUT = 4 cycles; return to IDLE; no writes.
- Dropped bytes: RX_D_VLD with 0xAA during WAIT_RES -> ignored. Result bytes unchanged; next frame parses normally.
